// File: rtl/zynq_pkg.sv
// Shared definitions for the zynq bsg_tag transmitter: field widths, packet record, FSM states.
package zynq_pkg;

    function automatic int safe_clog2(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

    localparam int tag_els_gp               = 16;
    localparam int tag_max_payload_width_gp = 1;
    localparam int tag_lg_els_gp            = safe_clog2(tag_els_gp);
    localparam int tag_lg_width_gp          = safe_clog2(tag_max_payload_width_gp + 1);
    localparam int tag_pkt_bits_gp          = 2 + tag_lg_width_gp + tag_lg_els_gp
                                              + tag_max_payload_width_gp;

    typedef struct packed {
        logic [tag_lg_els_gp-1:0]            nodeid;
        logic                                data_not_reset;
        logic [tag_lg_width_gp-1:0]          len;
        logic [tag_max_payload_width_gp-1:0] payload;
    } tag_pkt_s;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } tag_tx_state_e;

endpackage

// File: rtl/zynq_tag_piso.sv
// Parallel-load shift register; bit 0 is presented first and zeros fill from the top.
module zynq_tag_piso #(
    parameter int width_p = 8
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               load_i,
    input  logic               shift_i,
    input  logic [width_p-1:0] data_i,
    output logic               bit_o
);

    logic [width_p-1:0] data_q, data_d;

    always_comb begin
        data_d = data_q;
        if (load_i) begin
            data_d = data_i;
        end else if (shift_i) begin
            data_d = {1'b0, data_q[width_p-1:1]};
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign bit_o = data_q[0];

endmodule

// File: rtl/zynq_tag_tx.sv
// Serialises tag packets (start, len, data_not_reset, nodeid, payload; each LSB first)
// onto the bsg_tag line, one bit per clock.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | ready for a request; line held at 0
//   SEND    | shifting packet bits out; counter holds bits left minus one
//   GAP     | one forced zero cycle before the next request can be taken
module zynq_tag_tx
    import zynq_pkg::*;
#(
    parameter int els_p               = 16,
    parameter int max_payload_width_p = 1,
    parameter int lg_els_lp           = safe_clog2(els_p),
    parameter int lg_width_lp         = safe_clog2(max_payload_width_p + 1)
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic                           v_i,
    output logic                           ready_and_o,
    input  logic [lg_els_lp-1:0]           nodeid_i,
    input  logic                           data_not_reset_i,
    input  logic [lg_width_lp-1:0]         len_i,
    input  logic [max_payload_width_p-1:0] payload_i,
    output logic                           tag_data_o,
    output logic                           busy_o,
    output logic                           err_o
);

    localparam int hdr_bits_lp = 2 + lg_width_lp + lg_els_lp;
    localparam int pkt_bits_lp = hdr_bits_lp + max_payload_width_p;
    localparam int cnt_w_lp    = safe_clog2(pkt_bits_lp);

    tag_tx_state_e state_q, state_d;
    logic [cnt_w_lp-1:0] cnt_q, cnt_d;
    logic err_q, err_d;
    logic load, shift, sr_bit, len_bad;
    logic [max_payload_width_p-1:0] payload_mask;
    logic [pkt_bits_lp-1:0] load_vec;

    // Payload bits at or above len are zeroed so stale bits never reach the line.
    always_comb begin
        for (int i = 0; i < max_payload_width_p; i++) begin
            payload_mask[i] = (int'(len_i) > i);
        end
    end

    assign len_bad  = (int'(len_i) > max_payload_width_p);
    assign load_vec = {payload_i & payload_mask, nodeid_i, data_not_reset_i, len_i, 1'b1};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        load    = 1'b0;
        shift   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (v_i) begin
                    if (len_bad) begin
                        err_d = 1'b1;
                    end else begin
                        load    = 1'b1;
                        cnt_d   = cnt_w_lp'(hdr_bits_lp - 1) + cnt_w_lp'(len_i);
                        state_d = ST_SEND;
                    end
                end
            end
            ST_SEND: begin
                shift = 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q - cnt_w_lp'(1);
                end
            end
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    zynq_tag_piso #(.width_p(pkt_bits_lp)) piso (
        .aclk    (aclk),
        .aresetn (aresetn),
        .load_i  (load),
        .shift_i (shift),
        .data_i  (load_vec),
        .bit_o   (sr_bit)
    );

    // Gating by state makes the line drop to 0 the instant reset forces IDLE.
    assign tag_data_o  = (state_q == ST_SEND) & sr_bit;
    assign ready_and_o = (state_q == ST_IDLE);
    assign busy_o      = (state_q == ST_SEND) | (state_q == ST_GAP);
    assign err_o       = err_q;

endmodule

// File: doc/zynq_tag_tx.md
ZYNQ_TAG_TX -- requirements
Module: zynq_tag_tx

Interface
REQ-001 SHALL have parameter els_p, default 16, meaning the number of tag clients addressable.
REQ-002 SHALL have parameter max_payload_width_p, default 1, meaning the largest legal payload in bits.
REQ-003 SHALL have parameter lg_els_lp, derived as safe_clog2(els_p), meaning the nodeid field width (4 at default).
REQ-004 SHALL have parameter lg_width_lp, derived as safe_clog2(max_payload_width_p+1), meaning the len field width (1 at default).
REQ-005 SHALL have port aclk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port aresetn, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port v_i, input, 1, packet request valid.
REQ-008 SHALL have port ready_and_o, output, 1, the block accepts a packet when v_i & ready_and_o.
REQ-009 SHALL have port nodeid_i, input, lg_els_lp, the destination tag client.
REQ-010 SHALL have port data_not_reset_i, input, 1, the packet type: 1 = data, 0 = client reset.
REQ-011 SHALL have port len_i, input, lg_width_lp, the payload length in bits.
REQ-012 SHALL have port payload_i, input, max_payload_width_p, the payload; bit 0 is sent first.
REQ-013 SHALL have port tag_data_o, output, 1, the serial bsg_tag line driven to the tag master.
REQ-014 SHALL have port busy_o, output, 1, high while in SEND or GAP.
REQ-015 SHALL have port err_o, output, 1, a one-cycle pulse marking a rejected request.

Function
REQ-016 SHALL transmit each packet one bit per cycle, each field LSB first, in this order: start bit (1), len (lg_width_lp bits), data_not_reset, nodeid (lg_els_lp bits), payload (len bits).
REQ-017 SHALL give a packet length of 2+lg_width_lp+lg_els_lp+len bits; at default parameters with len=1 this is 8 bits.
REQ-018 SHALL drive tag_data_o to 0 whenever no packet bit is being sent.
REQ-019 SHALL implement the state machine IDLE -> SEND -> GAP -> IDLE.
REQ-020 SHALL drive ready_and_o = 1 only in IDLE; ready_and_o SHALL NOT depend combinationally on v_i.
REQ-021 SHALL, on an accepted request in cycle N, capture all inputs into a shift register and drive the start bit on tag_data_o in cycle N+1 (latency 1).
REQ-022 SHALL use a bit counter sized for the maximum packet length; on the last bit, SEND SHALL go to GAP.
REQ-023 SHALL remain in GAP for exactly 1 cycle with tag_data_o=0, then return to IDLE, giving a minimum 1-cycle zero gap between packets.
REQ-024 SHALL, for a request with len_i > max_payload_width_p, still accept it (ready_and_o high), pulse err_o in cycle N+1, send no bits, and remain in IDLE.
REQ-025 SHALL, for len_i = 0, omit the payload field entirely.
REQ-026 SHALL ignore payload bits above len_i.
REQ-027 SHALL ignore v_i while not in IDLE; inputs need not be held after acceptance.
REQ-028 SHALL support back-to-back requests, with the second accepted in the first IDLE cycle after GAP.

Reset
REQ-029 SHALL, while aresetn=0, asynchronously force state=IDLE, tag_data_o=0, busy_o=0, err_o=0, and clear the counter and shift register.
REQ-030 SHALL set ready_and_o=1 from the first cycle after aresetn deasserts.
REQ-031 SHALL abort a packet in flight when reset is asserted mid-packet; no resumption, and software re-initialises the tag master.

Structure
REQ-032 SHALL place a packet struct (nodeid, data_not_reset, len, payload) and its width constants in the shared zynq package, derived from tag_els_gp and tag_max_payload_width_gp.
REQ-033 SHALL use at most one sub-module, a parallel-load LSB-first shift register (zynq_tag_piso); the FSM and counter stay in zynq_tag_tx.

Verification
REQ-034 SHALL cover: nodeid=0, dnr=1, len=1, payload=1 -> tag_data_o = 1,1,1,0,0,0,0,1 on cycles N+1..N+8, then 0, with ready_and_o high again at N+10.
REQ-035 SHALL cover: nodeid=5, dnr=0, len=0 -> 1,0,0,1,0,1,0 (7 bits), then 0, with no payload bit.
REQ-036 SHALL cover: v_i held high for 3 packets -> each pair of packets separated by exactly one 0 cycle, and all 3 decode correctly.
REQ-037 SHALL cover: max_payload_width_p=2, len_i=3 -> err_o pulses once, tag_data_o stays 0, and state stays IDLE.
REQ-038 SHALL cover: aresetn low during bit 4 -> tag_data_o=0 immediately (asynchronously); after release, ready_and_o=1 and the next packet is bit-exact.
REQ-039 SHALL include a reference bsg_tag_master plus client in the bench, checking that the decoded client register equals the sent payload.
